// File: rtl/botassium_cpu_cpu_debug_master_vjtag_if.sv
// rtl/botassium_cpu_cpu_debug_master_vjtag_if.sv - command/response and virtual-JTAG signal bundle
interface botassium_cpu_cpu_debug_master_vjtag_if #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [IR_WIDTH-1:0] cmd_ir;
   logic [DR_WIDTH-1:0] cmd_dr;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DR_WIDTH-1:0] rsp_dr;
   logic                tck;
   logic                tdi;
   logic                tdo;
   logic [IR_WIDTH-1:0] ir_in;
   logic                vs_uir;
   logic                vs_cdr;
   logic                vs_sdr;
   logic                vs_udr;
   logic                jtag_state_rti;

   // Debug master side: takes commands, drives the virtual-JTAG slave.
   modport master (
      input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, tdo,
      output cmd_ready, rsp_valid, rsp_dr, tck, tdi, ir_in,
      output vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
   );

   // Host / slave-model side.
   modport slave (
      output cmd_valid, cmd_ir, cmd_dr, rsp_ready, tdo,
      input  cmd_ready, rsp_valid, rsp_dr, tck, tdi, ir_in,
      input  vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
   );
endinterface

// File: rtl/botassium_cpu_cpu_debug_master_vjtag.sv
// rtl/botassium_cpu_cpu_debug_master_vjtag.sv - virtual-JTAG debug master (optional DEBUG_MASTER_IR_SKIP_EN)
module botassium_cpu_cpu_debug_master_vjtag #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2,
   parameter int CLK_DIV  = 2
) (
   input  logic clk,
   input  logic reset,
   botassium_cpu_cpu_debug_master_vjtag_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          div_q;
   logic                tck_q;
   logic                tdi_q;
   logic [DR_WIDTH-1:0] sr_q;
   logic [DR_WIDTH-1:0] rsp_dr_q;
   logic                rsp_valid_q;
   logic [IR_WIDTH-1:0] ir_q;
   logic [5:0]          bit_q;

   logic accept;
   logic running;
   logic tick;
   logic rise;
   logic fall;
   logic skip_uir;

   assign accept  = (state_q == S_IDLE) && bus.cmd_valid;
   assign running = (state_q != S_IDLE) && (state_q != S_RESP);
   assign tick    = running && (div_q == 8'(CLK_DIV - 1));
   assign rise    = tick && !tck_q;
   assign fall    = tick && tck_q;

`ifdef DEBUG_MASTER_IR_SKIP_EN
   logic ir_known_q;

   // Remember that ir_q holds an IR already issued to the slave since reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_known_q <= 1'b0;
      end else if (accept) begin
         ir_known_q <= 1'b1;
      end
   end

   assign skip_uir = ir_known_q && (bus.cmd_ir == ir_q);
`else
   assign skip_uir = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: JTAG states advance only on a TCK fall so strobes are stable at every rise.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = skip_uir ? S_CDR : S_UIR;
         S_UIR:   if (fall) state_d = S_CDR;
         S_CDR:   if (fall) state_d = S_SHIFT;
         S_SHIFT: if (fall && (bit_q == 6'(DR_WIDTH))) state_d = S_UDR;
         S_UDR:   if (fall) state_d = S_RTI;
         S_RTI:   if (fall) state_d = S_RESP;
         S_RESP:  if (rsp_valid_q && bus.rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // TCK divider, shift register, bit counter and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q       <= '0;
         tck_q       <= 1'b0;
         tdi_q       <= 1'b0;
         sr_q        <= '0;
         rsp_dr_q    <= '0;
         rsp_valid_q <= 1'b0;
         ir_q        <= '0;
         bit_q       <= '0;
      end else begin
         if (!running || tick) begin
            div_q <= '0;
         end else begin
            div_q <= div_q + 8'd1;
         end

         if (tick) begin
            tck_q <= ~tck_q;
         end

         if (accept) begin
            ir_q  <= bus.cmd_ir;
            sr_q  <= bus.cmd_dr;
            tdi_q <= bus.cmd_dr[0];
            bit_q <= '0;
         end

         // Capture tdo on the rise, present the next tdi bit on the fall.
         if (state_q == S_SHIFT) begin
            if (rise) begin
               sr_q  <= {bus.tdo, sr_q[DR_WIDTH-1:1]};
               bit_q <= bit_q + 6'd1;
            end
            if (fall) begin
               tdi_q <= sr_q[0];
            end
         end

         // Publish the captured word once, then hold it until it is consumed.
         if (state_q == S_RESP) begin
            if (!rsp_valid_q) begin
               rsp_valid_q <= 1'b1;
               rsp_dr_q    <= sr_q;
            end else if (bus.rsp_ready) begin
               rsp_valid_q <= 1'b0;
            end
         end
      end
   end

   assign bus.cmd_ready      = (state_q == S_IDLE);
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_dr         = rsp_dr_q;
   assign bus.tck            = tck_q;
   assign bus.tdi            = tdi_q;
   assign bus.ir_in          = ir_q;
   assign bus.vs_uir         = (state_q == S_UIR);
   assign bus.vs_cdr         = (state_q == S_CDR);
   assign bus.vs_sdr         = (state_q == S_SHIFT);
   assign bus.vs_udr         = (state_q == S_UDR);
   assign bus.jtag_state_rti = (state_q == S_RTI);

endmodule

// File: tb/tb_botassium_cpu_cpu_debug_master_vjtag.sv
// tb/tb_botassium_cpu_cpu_debug_master_vjtag.sv - self-checking bench with loopback slave models
module tb_botassium_cpu_cpu_debug_master_vjtag;
   localparam int DW = 38;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   botassium_cpu_cpu_debug_master_vjtag_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) b2 ();
   botassium_cpu_cpu_debug_master_vjtag_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) b1 ();

   botassium_cpu_cpu_debug_master_vjtag #(.DR_WIDTH(DW), .IR_WIDTH(IW), .CLK_DIV(2)) dut2 (
      .clk(clk), .reset(reset), .bus(b2.master));
   botassium_cpu_cpu_debug_master_vjtag #(.DR_WIDTH(DW), .IR_WIDTH(IW), .CLK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .bus(b1.master));

   // Loopback slaves: load a preset at capture-DR, shift tdi in at shift-DR.
   logic [DW-1:0] s2_sr = '0, s2_pre = '0;
   logic [DW-1:0] s1_sr = '0, s1_pre = '0;
   always @(posedge b2.tck) begin
      if (b2.vs_cdr) s2_sr <= s2_pre;
      else if (b2.vs_sdr) s2_sr <= {b2.tdi, s2_sr[DW-1:1]};
   end
   always @(posedge b1.tck) begin
      if (b1.vs_cdr) s1_sr <= s1_pre;
      else if (b1.vs_sdr) s1_sr <= {b1.tdi, s1_sr[DW-1:1]};
   end
   assign b2.tdo = s2_sr[0];
   assign b1.tdo = s1_sr[0];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic run_cmd(input logic [1:0] ir, input logic [DW-1:0] dr, input logic [DW-1:0] pre,
                          input logic [DW-1:0] exp_rsp, input logic [DW-1:0] exp_slv,
                          input int exp_lat, input int exp_uir, input int hold);
      int n, w, cu, cc, cs, cd, cr, bad1h, irbad, holdbad;
      int fu, fc, fs, fd, fr;
      logic [DW-1:0] slv;
      logic [4:0] s;
      n = 0; w = 0; cu = 0; cc = 0; cs = 0; cd = 0; cr = 0; bad1h = 0; irbad = 0; holdbad = 0;
      fu = -1; fc = -1; fs = -1; fd = -1; fr = -1;
      slv = '0;
      s2_pre = pre;
      while (!b2.cmd_ready && w < 500) begin @(negedge clk); w++; end
      chk("cmd_ready_idle", b2.cmd_ready, 1);
      b2.cmd_ir = ir; b2.cmd_dr = dr; b2.cmd_valid = 1'b1;
      @(negedge clk);
      b2.cmd_valid = 1'b0; b2.cmd_ir = ~ir; b2.cmd_dr = ~dr;
      chk("cmd_ready_busy", b2.cmd_ready, 0);
      chk("tdi_first", b2.tdi, dr[0]);
      while (!b2.rsp_valid && n < 2000) begin
         s = {b2.vs_uir, b2.vs_cdr, b2.vs_sdr, b2.vs_udr, b2.jtag_state_rti};
         if (n < exp_lat - 1 && $countones(s) != 1) bad1h++;
         if (s[4]) begin cu++; if (fu < 0) fu = n; end
         if (s[3]) begin cc++; if (fc < 0) fc = n; end
         if (s[2]) begin cs++; if (fs < 0) fs = n; end
         if (s[1]) begin cd++; if (fd < 0) fd = n; slv = s2_sr; end
         if (s[0]) begin cr++; if (fr < 0) fr = n; end
         if (b2.ir_in !== ir) irbad++;
         @(negedge clk); n++;
      end
      chk("latency", n, exp_lat);
      chk("rsp_dr", b2.rsp_dr, exp_rsp);
      chk("slave_sr_at_udr", slv, exp_slv);
      chk("uir_cycles", cu, exp_uir);
      chk("cdr_cycles", cc, 4);
      chk("sdr_cycles", cs, DW * 4);
      chk("udr_cycles", cd, 4);
      chk("rti_cycles", cr, 4);
      chk("onehot_violations", bad1h, 0);
      chk("strobe_order", (fu < fc) && (fc < fs) && (fs < fd) && (fd < fr), 1);
      chk("ir_in_held", irbad, 0);
      for (int i = 0; i < hold; i++) begin
         if (!b2.rsp_valid || b2.rsp_dr !== exp_rsp || b2.cmd_ready || b2.tck) holdbad++;
         @(negedge clk);
      end
      chk("resp_hold_violations", holdbad, 0);
      b2.rsp_ready = 1'b1;
      @(negedge clk);
      b2.rsp_ready = 1'b0;
      chk("rsp_valid_after_hs", b2.rsp_valid, 0);
      chk("cmd_ready_after_hs", b2.cmd_ready, 1);
   endtask

   typedef struct {
      logic [1:0]    ir;
      logic [DW-1:0] dr;
      logic [DW-1:0] pre;
      logic [DW-1:0] exp_rsp;
      logic [DW-1:0] exp_slv;
      int            hold;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int w, r, t, acc1, acc2, r1, r2, vcnt;
      logic prev, prev_rdy;
      logic [DW-1:0] d1, d2;

      vecs[0] = '{2'b01, 38'h15_0F0F_F0F0, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0, 0};
      vecs[1] = '{2'b10, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 0};
      vecs[2] = '{2'b11, 38'h00_0000_0001, 38'h20_0000_0000, 38'h20_0000_0000, 38'h00_0000_0001, 0};
      vecs[3] = '{2'b00, 38'h2A_AAAA_5555, 38'h15_5555_AAAA, 38'h15_5555_AAAA, 38'h2A_AAAA_5555, 50};

      b2.cmd_valid = 1'b0; b2.cmd_ir = '0; b2.cmd_dr = '0; b2.rsp_ready = 1'b0;
      b1.cmd_valid = 1'b0; b1.cmd_ir = '0; b1.cmd_dr = '0; b1.rsp_ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", b2.cmd_ready, 1);
      chk("reset_outputs", {b2.rsp_valid, b2.tck, b2.tdi, b2.ir_in, b2.vs_uir, b2.vs_cdr,
                            b2.vs_sdr, b2.vs_udr, b2.jtag_state_rti}, 0);
      chk("reset_rsp_dr", b2.rsp_dr, 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++)
         run_cmd(vecs[i].ir, vecs[i].dr, vecs[i].pre, vecs[i].exp_rsp, vecs[i].exp_slv,
                 169, 4, vecs[i].hold);

      // Abort in the middle of SHIFT at bit 17.
      s2_pre = 38'h2A_5555_AAAA;
      b2.cmd_ir = 2'b11; b2.cmd_dr = 38'h15_0F0F_F0F0; b2.cmd_valid = 1'b1;
      @(negedge clk);
      b2.cmd_valid = 1'b0;
      r = 0; w = 0; prev = b2.tck;
      while (r < 17 && w < 2000) begin
         @(negedge clk); w++;
         if (b2.tck && !prev && b2.vs_sdr) r++;
         prev = b2.tck;
      end
      chk("reached_bit17", r, 17);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_cmd_ready", b2.cmd_ready, 1);
      chk("abort_outputs", {b2.rsp_valid, b2.tck, b2.tdi, b2.ir_in, b2.vs_uir, b2.vs_cdr,
                            b2.vs_sdr, b2.vs_udr, b2.jtag_state_rti}, 0);
      chk("abort_rsp_dr", b2.rsp_dr, 0);
      vcnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (b2.rsp_valid || b2.tck) vcnt++;
      end
      chk("abort_quiet", vcnt, 0);
      run_cmd(2'b11, 38'h15_0F0F_F0F0, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0,
              169, 4, 0);

      // Same IR twice in a row.
      run_cmd(2'b10, 38'h0A_1234_5678, 38'h35_CAFE_BABE, 38'h35_CAFE_BABE, 38'h0A_1234_5678,
              169, 4, 0);
`ifdef DEBUG_MASTER_IR_SKIP_EN
      run_cmd(2'b10, 38'h01_DEAD_BEEF, 38'h3E_0000_FFFF, 38'h3E_0000_FFFF, 38'h01_DEAD_BEEF,
              165, 0, 0);
`else
      run_cmd(2'b10, 38'h01_DEAD_BEEF, 38'h3E_0000_FFFF, 38'h3E_0000_FFFF, 38'h01_DEAD_BEEF,
              169, 4, 0);
`endif

      // CLK_DIV=1 instance, two commands back to back with rsp_ready held high.
      s1_pre = 38'h2A_5555_AAAA;
      b1.rsp_ready = 1'b1;
      b1.cmd_ir = 2'b01; b1.cmd_dr = 38'h15_0F0F_F0F0; b1.cmd_valid = 1'b1;
      t = 0; acc1 = -1; acc2 = -1; r1 = -1; r2 = -1; vcnt = 0; d1 = '0; d2 = '0;
      prev_rdy = b1.cmd_ready;
      while (r2 < 0 && t < 1000) begin
         @(negedge clk); t++;
         if (prev_rdy && b1.cmd_valid) begin
            if (acc1 < 0) begin
               acc1 = t;
               b1.cmd_ir = 2'b10; b1.cmd_dr = 38'h2A_AAAA_5555;
            end else begin
               acc2 = t;
               b1.cmd_valid = 1'b0;
            end
         end
         if (b1.rsp_valid) begin
            vcnt++;
            if (r1 < 0) begin r1 = t; d1 = b1.rsp_dr; end
            else if (acc2 >= 0) begin r2 = t; d2 = b1.rsp_dr; end
         end
         prev_rdy = b1.cmd_ready;
      end
      @(negedge clk);
      b1.rsp_ready = 1'b0;
      chk("div1_lat1", r1 - acc1, 85);
      chk("div1_accept2", acc2 - r1, 2);
      chk("div1_lat2", r2 - acc2, 85);
      chk("div1_rsp1", d1, 38'h2A_5555_AAAA);
      chk("div1_rsp2", d2, 38'h2A_5555_AAAA);
      chk("div1_valid_cycles", vcnt, 2);
      chk("div1_slave_sr", s1_sr, 38'h2A_AAAA_5555);
      chk("div1_idle_after", {b1.cmd_ready, b1.rsp_valid}, 2'b10);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
